rs_pair: RTL

//   Receiving end of the dual instruction dispatch buses: one pair of reservation stations
//   (entries RS_ID0/RS_ID1) for a single functional-unit class (ADD, MULT, FETCH or STORE).

---
 rtl/rs_pair_if.sv | 40 ++++
 rtl/rs_pair.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rs_pair_if.sv
// Bundle of the dispatch buses, CDB snoop, FU issue handshake and free-status
// return seen by one reservation-station pair.
interface rs_pair_if #(
    parameter int INS_PART_WID = 4,
    parameter int TAG_LEN      = 4,
    parameter int DATA_WID     = 16
);
    logic [3*INS_PART_WID-1:0] instruction1;
    logic                      instruction1_valid;
    logic [DATA_WID-1:0]       inst1_op0_val;
    logic [DATA_WID-1:0]       inst1_op1_val;
    logic [3*INS_PART_WID-1:0] instruction2;
    logic                      instruction2_valid;
    logic [DATA_WID-1:0]       inst2_op0_val;
    logic [DATA_WID-1:0]       inst2_op1_val;
    logic                      cdb_valid;
    logic [TAG_LEN-1:0]        cdb_tag;
    logic [DATA_WID-1:0]       cdb_data;
    logic                      fu_req;
    logic [TAG_LEN-1:0]        fu_tag;
    logic [DATA_WID-1:0]       fu_op0;
    logic [DATA_WID-1:0]       fu_op1;
    logic                      fu_ack;
    logic [1:0]                rs_done;
    logic                      protocol_err;

    modport master (
        output instruction1, instruction1_valid, inst1_op0_val, inst1_op1_val,
        output instruction2, instruction2_valid, inst2_op0_val, inst2_op1_val,
        output cdb_valid, cdb_tag, cdb_data, fu_ack,
        input  fu_req, fu_tag, fu_op0, fu_op1, rs_done, protocol_err
    );

    modport slave (
        input  instruction1, instruction1_valid, inst1_op0_val, inst1_op1_val,
        input  instruction2, instruction2_valid, inst2_op0_val, inst2_op1_val,
        input  cdb_valid, cdb_tag, cdb_data, fu_ack,
        output fu_req, fu_tag, fu_op0, fu_op1, rs_done, protocol_err
    );
endinterface

// File: rtl/rs_pair.sv
// Pair of reservation stations for one functional-unit class: captures dispatched
// instructions, resolves operand tags from the CDB, issues oldest-ready to the FU.
module rs_pair #(
    parameter int                      INS_PART_WID = 4,
    parameter int                      TAG_LEN      = 4,
    parameter int                      DATA_WID     = 16,
    parameter logic [INS_PART_WID-1:0] RS_ID0       = 4'b0001,
    parameter logic [INS_PART_WID-1:0] RS_ID1       = 4'b0010
) (
    input  logic      clk,
    input  logic      rst,
    rs_pair_if.slave  bus
);

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_ISSUED} state_t;

    state_t              state_q [2];
    state_t              state_d [2];
    logic [DATA_WID-1:0] val_q   [2][2];
    logic [DATA_WID-1:0] val_d   [2][2];
    logic [TAG_LEN-1:0]  tag_q   [2][2];
    logic [TAG_LEN-1:0]  tag_d   [2][2];
    logic                pend_q  [2][2];
    logic                pend_d  [2][2];
    logic                older_q, older_d;
    logic                lock_q, lock_sel_q;
    logic                sel;
    logic [1:0]          done_q;
    logic                err_q, err_d;

    logic [TAG_LEN-1:0]  rs_id   [2];
    logic [TAG_LEN-1:0]  id_b    [2];
    logic [TAG_LEN-1:0]  src_tag [2][2];
    logic [DATA_WID-1:0] src_val [2][2];
    logic [1:0]          hit1, hit2, take, own_cdb, rdy;
    logic                fu_req;

    assign rs_id[0]       = RS_ID0;
    assign rs_id[1]       = RS_ID1;
    assign id_b[0]        = bus.instruction1[3*INS_PART_WID-1 -: INS_PART_WID];
    assign src_tag[0][0]  = bus.instruction1[2*INS_PART_WID-1 -: INS_PART_WID];
    assign src_tag[0][1]  = bus.instruction1[INS_PART_WID-1:0];
    assign src_val[0][0]  = bus.inst1_op0_val;
    assign src_val[0][1]  = bus.inst1_op1_val;
    assign id_b[1]        = bus.instruction2[3*INS_PART_WID-1 -: INS_PART_WID];
    assign src_tag[1][0]  = bus.instruction2[2*INS_PART_WID-1 -: INS_PART_WID];
    assign src_tag[1][1]  = bus.instruction2[INS_PART_WID-1:0];
    assign src_val[1][0]  = bus.inst2_op0_val;
    assign src_val[1][1]  = bus.inst2_op1_val;

    always_comb begin
        hit1    = '0;
        hit2    = '0;
        take    = '0;
        own_cdb = '0;
        rdy     = '0;
        for (int i = 0; i < 2; i++) begin
            hit1[i]    = bus.instruction1_valid && (id_b[0] == rs_id[i]);
            hit2[i]    = bus.instruction2_valid && (id_b[1] == rs_id[i]);
            take[i]    = (hit1[i] || hit2[i]) && (state_q[i] == ST_FREE);
            own_cdb[i] = bus.cdb_valid && (bus.cdb_tag == rs_id[i]);
            rdy[i]     = (state_q[i] == ST_READY);
        end
    end

    // A request that was not acked keeps its entry selected so the FU sees stable operands.
    assign fu_req = rdy[0] || rdy[1];

    always_comb begin
        if (lock_q)
            sel = lock_sel_q;
        else if (rdy[0] && rdy[1])
            sel = older_q;
        else
            sel = rdy[1];
    end

    assign bus.fu_req       = fu_req;
    assign bus.fu_tag       = fu_req ? rs_id[sel]     : '0;
    assign bus.fu_op0       = fu_req ? val_q[sel][0]  : '0;
    assign bus.fu_op1       = fu_req ? val_q[sel][1]  : '0;
    assign bus.rs_done      = done_q;
    assign bus.protocol_err = err_q;

    always_comb begin
        logic                bsel;
        logic [TAG_LEN-1:0]  stag;
        logic [DATA_WID-1:0] sval;
        bsel    = 1'b0;
        stag    = '0;
        sval    = '0;
        err_d   = 1'b0;
        older_d = older_q;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            for (int k = 0; k < 2; k++) begin
                val_d[i][k]  = val_q[i][k];
                tag_d[i][k]  = tag_q[i][k];
                pend_d[i][k] = pend_q[i][k];
            end
            if ((hit1[i] && hit2[i]) ||
                ((hit1[i] || hit2[i]) && (state_q[i] != ST_FREE)) ||
                (own_cdb[i] && (state_q[i] != ST_ISSUED)))
                err_d = 1'b1;
            case (state_q[i])
                ST_FREE: begin
                    if (hit1[i] || hit2[i]) begin
                        bsel = !hit1[i];
                        for (int k = 0; k < 2; k++) begin
                            stag = src_tag[bsel][k];
                            sval = src_val[bsel][k];
                            if (stag == '0) begin
                                val_d[i][k]  = sval;
                                pend_d[i][k] = 1'b0;
                            end else if (bus.cdb_valid && (bus.cdb_tag == stag)) begin
                                val_d[i][k]  = bus.cdb_data;
                                pend_d[i][k] = 1'b0;
                            end else begin
                                tag_d[i][k]  = stag;
                                pend_d[i][k] = 1'b1;
                            end
                        end
                        state_d[i] = (pend_d[i][0] || pend_d[i][1]) ? ST_WAIT : ST_READY;
                    end
                end
                ST_WAIT: begin
                    for (int k = 0; k < 2; k++) begin
                        if (pend_q[i][k] && bus.cdb_valid && (bus.cdb_tag == tag_q[i][k])) begin
                            val_d[i][k]  = bus.cdb_data;
                            pend_d[i][k] = 1'b0;
                        end
                    end
                    if (!pend_d[i][0] && !pend_d[i][1])
                        state_d[i] = ST_READY;
                end
                ST_READY: begin
                    if (bus.fu_ack && (sel == 1'(i)))
                        state_d[i] = ST_ISSUED;
                end
                ST_ISSUED: begin
                    if (own_cdb[i])
                        state_d[i] = ST_FREE;
                end
                default: state_d[i] = ST_FREE;
            endcase
        end
        // Age: an entry dispatched while its sibling is occupied is the younger one.
        if (take[0] && take[1])
            older_d = hit1[1];
        else if (take[0])
            older_d = (state_q[1] != ST_FREE);
        else if (take[1])
            older_d = (state_q[0] == ST_FREE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i]   <= ST_FREE;
                pend_q[i][0] <= 1'b0;
                pend_q[i][1] <= 1'b0;
            end
            older_q    <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            done_q     <= 2'b11;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i]   <= state_d[i];
                pend_q[i][0] <= pend_d[i][0];
                pend_q[i][1] <= pend_d[i][1];
            end
            older_q    <= older_d;
            lock_q     <= fu_req && !bus.fu_ack;
            lock_sel_q <= sel;
            done_q     <= {state_d[1] == ST_FREE, state_d[0] == ST_FREE};
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        val_q <= val_d;
        tag_q <= tag_d;
    end

endmodule
